// File: rtl/sys_arr_pkg.sv
// Shared parameters and FSM state type for the systolic array controller.
// Optional performance counters in the top are enabled by SYS_ARR_PERF_CNT_EN.
package sys_arr_pkg;

  localparam int N        = 4;
  localparam int MAX_ROWS = 256;
  localparam int CW       = $clog2(MAX_ROWS + 1);
  localparam int RW       = (N > 1) ? $clog2(N) : 1;
  localparam int LAT      = 2 * N - 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/sys_arr_perf_counter.sv
// 32-bit event counter with synchronous clear; clear wins over enable.
module sys_arr_perf_counter (
  input  logic        clk,
  input  logic        nRST,
  input  logic        clear,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/systolic_array_controller.sv
// Job sequencer for an NxN weight-stationary systolic array: weight preload,
// row streaming, skew drain, done pulse. Define SYS_ARR_PERF_CNT_EN for perf counters.
module systolic_array_controller
  import sys_arr_pkg::*;
(
  input  logic          clk,
  input  logic          nRST,
  input  logic          start,
  input  logic [CW-1:0] num_rows,
  input  logic          w_valid,
  output logic          w_ready,
  output logic          weight_en,
  output logic [RW-1:0] weight_row,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mac_start,
  input  logic          value_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_row,
  output logic          busy,
  output logic          done
`ifdef SYS_ARR_PERF_CNT_EN
  ,
  output logic [31:0]   perf_busy,
  output logic [31:0]   perf_stall
`endif
);

  localparam logic [CW-1:0] LAT_C    = CW'(LAT);
  localparam logic [CW-1:0] W_LAST_C = CW'(N - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  ctrl_state_t   state, state_nxt;
  logic [CW-1:0] m_reg;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] icnt;
  logic [CW-1:0] step_cnt;
  logic [CW-1:0] total_steps;
  logic          legal;
  logic          start_acc;
  logic          emits_row;

  // Once results start leaving the array, every step pushes a row out,
  // so a step then also needs the consumer to be ready.
  assign legal       = value_ready & ((step_cnt < LAT_C) | out_ready);
  assign total_steps = m_reg + LAT_C;
  assign start_acc   = (state == IDLE) & start;
  assign emits_row   = mac_start & (step_cnt >= LAT_C);

  always_comb begin
    state_nxt  = state;
    w_ready    = 1'b0;
    weight_en  = 1'b0;
    weight_row = '0;
    in_ready   = 1'b0;
    mac_start  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_rows != '0) ? LOAD_W : DONE;
        end
      end
      LOAD_W: begin
        w_ready    = 1'b1;
        weight_en  = w_valid;
        weight_row = w_valid ? wcnt[RW-1:0] : '0;
        if (w_valid && (wcnt == W_LAST_C)) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        in_ready  = legal;
        mac_start = legal & in_valid;
        if (mac_start && ((icnt + ONE_C) == m_reg)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // With a zero-latency array the skew is already flushed on entry.
        if (step_cnt == total_steps) begin
          state_nxt = DONE;
        end else begin
          mac_start = legal;
          if (legal && ((step_cnt + ONE_C) == total_steps)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state     <= IDLE;
      m_reg     <= '0;
      wcnt      <= '0;
      icnt      <= '0;
      step_cnt  <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= emits_row;
      if (start_acc) begin
        m_reg    <= num_rows;
        wcnt     <= '0;
        icnt     <= '0;
        step_cnt <= '0;
      end
      if (weight_en) begin
        wcnt <= wcnt + ONE_C;
      end
      if (mac_start && (state == STREAM)) begin
        icnt <= icnt + ONE_C;
      end
      if (mac_start) begin
        step_cnt <= step_cnt + ONE_C;
      end
      if (emits_row) begin
        out_row <= step_cnt - LAT_C;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef SYS_ARR_PERF_CNT_EN
  logic busy_cycle;
  logic stall_cycle;

  assign busy_cycle  = (state == LOAD_W) | (state == STREAM) | (state == DRAIN);
  assign stall_cycle = ((state == STREAM) | (state == DRAIN)) & ~mac_start;

  sys_arr_perf_counter u_perf_busy (
    .clk   (clk),
    .nRST  (nRST),
    .clear (start_acc),
    .en    (busy_cycle),
    .count (perf_busy)
  );

  sys_arr_perf_counter u_perf_stall (
    .clk   (clk),
    .nRST  (nRST),
    .clear (start_acc),
    .en    (stall_cycle),
    .count (perf_stall)
  );
`endif

endmodule
